// File: rtl/klp32_alu_pkg.sv
// Shared ALU definitions: operation encoding and the carry-in helper used by
// every adder that supports both addition and subtraction.
package klp32_alu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

  // Subtraction runs as X + ~Y + ~borrow, so the adder sees the inverted borrow.
  function automatic logic effCarryIn(input logic opSel, input logic carryIn);
    return (opSel == OP_SUB) ? ~carryIn : carryIn;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One slice of the pipelined adder: a CW-bit ripple add with carry in/out.
module addsub_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  // Widen by one bit so the top bit of the add is the chunk carry-out.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit. The operands are cut into STAGES chunks; each
// stage adds one chunk using the carry registered by the stage before it.
// Upper operand chunks travel down the pipe (rotated so the next chunk is
// always at the bottom) and finished sum chunks accumulate, so the full
// result, flags and tag leave together from a registered output stage.
// The whole pipe freezes while the output holds an unconsumed result.
module addsub_pipe
  import klp32_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic             carryin,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int CW          = WIDTH / SAFE_STAGES;
  localparam int LAST        = SAFE_STAGES - 1;

  if ((STAGES < 1) || ((WIDTH % SAFE_STAGES) != 0)) begin : g_bad_params
    $error("addsub_pipe: STAGES must be >= 1 and divide WIDTH evenly");
  end

  logic             stall;
  logic [WIDTH-1:0] yEff;
  logic             cinEff;

  logic             valid_q [SAFE_STAGES];
  logic [TAG_W-1:0] tag_q   [SAFE_STAGES];
  logic [WIDTH-1:0] x_q     [SAFE_STAGES];
  logic [WIDTH-1:0] y_q     [SAFE_STAGES];
  logic [WIDTH-1:0] sum_q   [SAFE_STAGES];
  logic             carry_q [SAFE_STAGES];

  logic             valid_d [SAFE_STAGES];
  logic [TAG_W-1:0] tag_d   [SAFE_STAGES];
  logic [WIDTH-1:0] x_d     [SAFE_STAGES];
  logic [WIDTH-1:0] y_d     [SAFE_STAGES];
  logic [WIDTH-1:0] sum_d   [SAFE_STAGES];
  logic             carry_d [SAFE_STAGES];

  logic             outValid_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;
  logic [TAG_W-1:0] outTag_q;
  logic             ovf_d;

  assign stall    = outValid_q && !out_ready;
  assign in_ready = !stall;

  assign yEff   = (op == OP_SUB) ? ~Y : Y;
  assign cinEff = effCarryIn(op, carryin);

  for (genvar k = 0; k < SAFE_STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] srcX;
    logic [WIDTH-1:0] srcY;
    logic [WIDTH-1:0] srcSum;
    logic             srcCin;
    logic [CW-1:0]    chunkSum;
    logic             chunkCout;

    if (k == 0) begin : g_head
      assign srcX       = X;
      assign srcY       = yEff;
      assign srcSum     = '0;
      assign srcCin     = cinEff;
      assign valid_d[k] = in_valid;
      assign tag_d[k]   = in_tag;
    end else begin : g_body
      assign srcX       = x_q[k-1];
      assign srcY       = y_q[k-1];
      assign srcSum     = sum_q[k-1];
      assign srcCin     = carry_q[k-1];
      assign valid_d[k] = valid_q[k-1];
      assign tag_d[k]   = tag_q[k-1];
    end

    addsub_chunk #(.CW(CW)) u_chunk (
      .a    (srcX[CW-1:0]),
      .b    (srcY[CW-1:0]),
      .cin  (srcCin),
      .sum  (chunkSum),
      .cout (chunkCout)
    );

    assign x_d[k]     = (srcX >> CW) | (srcX << (WIDTH - CW));
    assign y_d[k]     = (srcY >> CW) | (srcY << (WIDTH - CW));
    assign sum_d[k]   = srcSum | (WIDTH'(chunkSum) << (k * CW));
    assign carry_d[k] = chunkCout;
  end

  // After STAGES rotations the carried operands are back in original order.
  assign ovf_d = (x_q[LAST][WIDTH-1] == y_q[LAST][WIDTH-1]) &&
                 (sum_q[LAST][WIDTH-1] != x_q[LAST][WIDTH-1]);

  // Advance every stage and the output together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SAFE_STAGES; k++) begin
        valid_q[k] <= 1'b0;
        tag_q[k]   <= '0;
        x_q[k]     <= '0;
        y_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      outValid_q <= 1'b0;
      s_q        <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      outTag_q   <= '0;
    end else if (!stall) begin
      for (int k = 0; k < SAFE_STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        tag_q[k]   <= tag_d[k];
        x_q[k]     <= x_d[k];
        y_q[k]     <= y_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
      end
      outValid_q <= valid_q[LAST];
      s_q        <= sum_q[LAST];
      cout_q     <= carry_q[LAST];
      ovf_q      <= ovf_d;
      zero_q     <= (sum_q[LAST] == '0);
      neg_q      <= sum_q[LAST][WIDTH-1];
      outTag_q   <= tag_q[LAST];
    end
  end

  assign out_valid = outValid_q;
  assign S         = s_q;
  assign carryout  = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign out_tag   = outTag_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed checks on a 32-bit/4-stage
// instance and randomized valid/ready traffic on 16-bit 1- and 8-stage ones.
module tb_addsub_pipe;
  import klp32_alu_pkg::*;

  localparam int MAIN_ST = 4;

  typedef struct {
    longint unsigned s;
    logic            c;
    logic            ov;
    logic            z;
    logic            n;
  } res_t;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        ov;
    logic        z;
    logic        n;
    logic [3:0]  tag;
    int          acc;
    int          stallMark;
    bit          seen;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic        inValid, inReady, op, cin, outValid, outReady;
  logic [31:0] x, y, s;
  logic [3:0]  inTag, outTag;
  logic        cout, ovf, zero, neg;

  logic        rInValid [2];
  logic        rInReady [2];
  logic        rOp      [2];
  logic        rCin     [2];
  logic [15:0] rX       [2];
  logic [15:0] rY       [2];
  logic [3:0]  rInTag   [2];
  logic        rOutValid[2];
  logic        rOutReady[2];
  logic [15:0] rS       [2];
  logic        rCout    [2];
  logic        rOvf     [2];
  logic        rZero    [2];
  logic        rNeg     [2];
  logic [3:0]  rOutTag  [2];

  addsub_pipe #(.WIDTH(32), .STAGES(MAIN_ST), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .op(op), .carryin(cin), .X(x), .Y(y), .in_tag(inTag),
    .out_valid(outValid), .out_ready(outReady), .S(s), .carryout(cout),
    .overflow(ovf), .zero(zero), .negative(neg), .out_tag(outTag)
  );

  addsub_pipe #(.WIDTH(16), .STAGES(1), .TAG_W(4)) dutS1 (
    .clk(clk), .reset(reset), .in_valid(rInValid[0]), .in_ready(rInReady[0]),
    .op(rOp[0]), .carryin(rCin[0]), .X(rX[0]), .Y(rY[0]), .in_tag(rInTag[0]),
    .out_valid(rOutValid[0]), .out_ready(rOutReady[0]), .S(rS[0]), .carryout(rCout[0]),
    .overflow(rOvf[0]), .zero(rZero[0]), .negative(rNeg[0]), .out_tag(rOutTag[0])
  );

  addsub_pipe #(.WIDTH(16), .STAGES(8), .TAG_W(4)) dutS8 (
    .clk(clk), .reset(reset), .in_valid(rInValid[1]), .in_ready(rInReady[1]),
    .op(rOp[1]), .carryin(rCin[1]), .X(rX[1]), .Y(rY[1]), .in_tag(rInTag[1]),
    .out_valid(rOutValid[1]), .out_ready(rOutReady[1]), .S(rS[1]), .carryout(rCout[1]),
    .overflow(rOvf[1]), .zero(rZero[1]), .negative(rNeg[1]), .out_tag(rOutTag[1])
  );

  // Reference result from integer arithmetic: the signed flag comes from
  // checking whether the true signed result fits in w bits.
  function automatic res_t refModel(input int w, input logic opSel, input logic cinBit,
                                    input longint unsigned a, input longint unsigned b);
    res_t            r;
    longint unsigned mask, full;
    longint          sa, sb, sv, maxV, minV;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a);
    sb = longint'(b);
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
    maxV = (longint'(1) << (w - 1)) - 1;
    minV = -(longint'(1) << (w - 1));
    if (opSel == OP_SUB) begin
      full = a + (mask - b) + (cinBit ? 64'd0 : 64'd1);
      sv   = sa - sb - (cinBit ? longint'(1) : longint'(0));
    end else begin
      full = a + b + (cinBit ? 64'd1 : 64'd0);
      sv   = sa + sb + (cinBit ? longint'(1) : longint'(0));
    end
    r.s  = full & mask;
    r.c  = full[w];
    r.ov = (sv > maxV) || (sv < minV);
    r.z  = (r.s == 64'd0);
    r.n  = r.s[w-1];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkMain(input string tag, input res_t e, input logic [3:0] t);
    checkOutput({tag, "_valid"}, 64'(outValid), 64'd1);
    checkOutput({tag, "_s"}, 64'(s), e.s);
    checkOutput({tag, "_flags"}, 64'({cout, ovf, zero, neg}), 64'({e.c, e.ov, e.z, e.n}));
    checkOutput({tag, "_tag"}, 64'(outTag), 64'(t));
  endtask

  task automatic applyStimulus(input logic o, input logic c, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] t);
    inValid = 1'b1;
    op      = o;
    cin     = c;
    x       = a;
    y       = b;
    inTag   = t;
  endtask

  task automatic idleInputs();
    inValid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation through an otherwise empty pipe, result expected exactly MAIN_ST edges later.
  task automatic runSingle(input string tag, input logic o, input logic c, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] t, input res_t e);
    applyStimulus(o, c, a, b, t);
    tick();
    idleInputs();
    checkOutput({tag, "_lat0"}, 64'(outValid), 64'd0);
    for (int i = 1; i <= MAIN_ST; i++) begin
      tick();
      if (i < MAIN_ST) checkOutput({tag, "_early"}, 64'(outValid), 64'd0);
      else checkMain(tag, e, t);
    end
    tick();
    checkOutput({tag, "_gone"}, 64'(outValid), 64'd0);
  endtask

  task automatic runRandom(input int d);
    exp_t q[$];
    exp_t e;
    res_t r;
    int   stages, accepted, cyc, stallCount;
    logic acc, con;
    stages     = (d == 0) ? 1 : 8;
    accepted   = 0;
    cyc        = 0;
    stallCount = 0;
    while ((accepted < 1000 || q.size() != 0) && cyc < 20000) begin
      if (rOutValid[d]) begin
        if (q.size() == 0) begin
          checkOutput("rand_spurious", 64'(rOutValid[d]), 64'd0);
        end else if (!q[0].seen) begin
          q[0].seen = 1'b1;
          if (q[0].stallMark == stallCount)
            checkOutput("rand_latency", 64'(cyc - q[0].acc), 64'(stages));
        end
      end
      rInValid[d]  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      rOp[d]       = 1'($urandom);
      rCin[d]      = 1'($urandom);
      rX[d]        = 16'($urandom);
      rY[d]        = 16'($urandom);
      rInTag[d]    = 4'($urandom);
      rOutReady[d] = ($urandom_range(0, 3) != 0);
      #1;
      acc = rInValid[d] && rInReady[d];
      con = rOutValid[d] && rOutReady[d];
      if (rOutValid[d] && !rOutReady[d]) stallCount++;
      if (con && q.size() != 0) begin
        e = q.pop_front();
        checkOutput("rand_result",
                    64'({rS[d], rCout[d], rOvf[d], rZero[d], rNeg[d], rOutTag[d]}),
                    64'({e.s, e.c, e.ov, e.z, e.n, e.tag}));
      end
      if (acc) begin
        r           = refModel(16, rOp[d], rCin[d], 64'(rX[d]), 64'(rY[d]));
        e.s         = r.s[15:0];
        e.c         = r.c;
        e.ov        = r.ov;
        e.z         = r.z;
        e.n         = r.n;
        e.tag       = rInTag[d];
        e.acc       = cyc + 1;
        e.stallMark = stallCount;
        e.seen      = 1'b0;
        q.push_back(e);
        accepted++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    rInValid[d]  = 1'b0;
    rOutReady[d] = 1'b1;
    checkOutput("rand_accepted", 64'(accepted), 64'd1000);
    checkOutput("rand_drained", 64'(q.size()), 64'd0);
  endtask

  res_t        eFix;
  res_t        eRun;
  res_t        eArr [8];
  logic        oArr [8];
  logic        cArr [8];
  logic [31:0] aArr [8];
  logic [31:0] bArr [8];
  logic [31:0] aTmp, bTmp;

  initial begin
    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b1;
    op       = 1'b0;
    cin      = 1'b0;
    x        = '0;
    y        = '0;
    inTag    = '0;
    for (int d = 0; d < 2; d++) begin
      rInValid[d]  = 1'b0;
      rOutReady[d] = 1'b1;
      rOp[d]       = 1'b0;
      rCin[d]      = 1'b0;
      rX[d]        = '0;
      rY[d]        = '0;
      rInTag[d]    = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(outValid), 64'd0);
    checkOutput("reset_s", 64'(s), 64'd0);
    checkOutput("reset_flags", 64'({cout, ovf, zero, neg}), 64'd0);
    checkOutput("reset_tag", 64'(outTag), 64'd0);
    reset = 1'b0;
    tick();
    checkOutput("post_reset_in_ready", 64'(inReady), 64'd1);

    // Carry out of the MSB wrapping to zero
    eFix.s = 64'h0; eFix.c = 1'b1; eFix.ov = 1'b0; eFix.z = 1'b1; eFix.n = 1'b0;
    runSingle("add_wrap", OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3, eFix);

    // Most negative minus one overflows to the most positive
    eFix.s = 64'h7FFF_FFFF; eFix.c = 1'b1; eFix.ov = 1'b1; eFix.z = 1'b0; eFix.n = 1'b0;
    runSingle("sub_ovf", OP_SUB, 1'b0, 32'h8000_0000, 32'h0000_0001, 4'd9, eFix);

    // Carry-in and borrow-in boundaries
    runSingle("add_cin", OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h0,
              4'd5, refModel(32, OP_ADD, 1'b1, 64'h7FFF_FFFF, 64'h0));
    runSingle("sub_bin", OP_SUB, 1'b1, 32'h0, 32'h0,
              4'd6, refModel(32, OP_SUB, 1'b1, 64'h0, 64'h0));

    // Eight back-to-back operations with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      oArr[i] = 1'($urandom);
      cArr[i] = 1'($urandom);
      aArr[i] = $urandom;
      bArr[i] = $urandom;
      eArr[i] = refModel(32, oArr[i], cArr[i], 64'(aArr[i]), 64'(bArr[i]));
    end
    for (int c = 0; c < 8 + MAIN_ST; c++) begin
      if (c < 8) applyStimulus(oArr[c], cArr[c], aArr[c], bArr[c], 4'(c));
      else idleInputs();
      tick();
      if (c >= MAIN_ST) checkMain("b2b", eArr[c - MAIN_ST], 4'(c - MAIN_ST));
      else checkOutput("b2b_fill", 64'(outValid), 64'd0);
    end
    tick();
    checkOutput("b2b_empty", 64'(outValid), 64'd0);

    // Full pipe held for three stalled edges, then released
    for (int i = 0; i < 6; i++) begin
      oArr[i] = 1'($urandom);
      cArr[i] = 1'($urandom);
      aArr[i] = $urandom;
      bArr[i] = $urandom;
      eArr[i] = refModel(32, oArr[i], cArr[i], 64'(aArr[i]), 64'(bArr[i]));
    end
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(oArr[i], cArr[i], aArr[i], bArr[i], 4'(8 + i));
      tick();
    end
    applyStimulus(oArr[5], cArr[5], aArr[5], bArr[5], 4'(13));
    #1;
    checkOutput("stall_full_in_ready", 64'(inReady), 64'd0);
    checkMain("stall_head", eArr[0], 4'(8));
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("stall_in_ready", 64'(inReady), 64'd0);
      checkMain("stall_hold", eArr[0], 4'(8));
    end
    outReady = 1'b1;
    #1;
    checkOutput("stall_release_in_ready", 64'(inReady), 64'd1);
    tick();
    idleInputs();
    for (int j = 1; j <= 5; j++) begin
      checkMain("stall_drain", eArr[j], 4'(8 + j));
      tick();
    end
    checkOutput("stall_empty", 64'(outValid), 64'd0);

    // Reset with three operations in flight and a fourth presented on the reset edge
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom, 4'(i));
      tick();
    end
    applyStimulus(OP_ADD, 1'b0, 32'h1234_5678, 32'h1111_1111, 4'd15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idleInputs();
    checkOutput("rst_mid_valid", 64'(outValid), 64'd0);
    checkOutput("rst_mid_s", 64'(s), 64'd0);
    checkOutput("rst_mid_in_ready", 64'(inReady), 64'd1);
    for (int i = 0; i < MAIN_ST + 2; i++) begin
      tick();
      checkOutput("rst_flush", 64'(outValid), 64'd0);
    end
    aTmp = $urandom;
    bTmp = $urandom;
    eRun = refModel(32, OP_SUB, 1'b1, 64'(aTmp), 64'(bTmp));
    runSingle("post_rst", OP_SUB, 1'b1, aTmp, bTmp, 4'd7, eRun);

    // Randomized traffic on the 1-stage and 8-stage 16-bit instances
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    runRandom(0);
    runRandom(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; WIDTH mod STAGES == 0 and STAGES >= 1, otherwise elaboration SHALL fail.
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each operation.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operation presented.
REQ-008 in_ready  output  1  block accepts operation this cycle.
REQ-009 op  input  1  0 = ADD, 1 = SUB.
REQ-010 carryin  input  1  carry-in for ADD, borrow-in for SUB.
REQ-011 X, Y  input  WIDTH  operands.
REQ-012 in_tag  input  TAG_W  sideband, returned unchanged.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 S  output  WIDTH  result.
REQ-016 carryout  output  1  carry out of the MSB of the internal addition.
REQ-017 overflow, zero, negative  output  1 each  signed overflow, S==0, S[WIDTH-1].
REQ-018 out_tag  output  TAG_W  tag of the operation producing S.

Function
REQ-019 ADD SHALL compute X + Y + carryin; SUB SHALL compute X + ~Y + ~carryin (i.e. X - Y - carryin), modulo 2^WIDTH.
REQ-020 carryout SHALL be bit WIDTH of the internal sum (for SUB, 1 = no borrow).
REQ-021 overflow SHALL be (X[MSB] == Y'[MSB]) && (S[MSB] != X[MSB]), where Y' is the operand actually added.
REQ-022 Operands SHALL be split into STAGES chunks of WIDTH/STAGES bits; stage k SHALL add chunk k using the carry registered from stage k-1 (stage 0 uses the effective carry-in).
REQ-023 Unprocessed upper chunks SHALL be skewed (delayed) and completed lower chunks de-skewed so all S bits, flags and tag emerge together.
REQ-024 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid high, absent stalls.
REQ-025 An operation SHALL be accepted on an edge where in_valid && in_ready; a result SHALL be consumed on an edge where out_valid && out_ready.
REQ-026 stall = out_valid && !out_ready; in_ready SHALL equal !stall (combinational).
REQ-027 During stall all pipeline registers, valids and outputs SHALL hold; no operation is lost or duplicated.
REQ-028 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-029 Bubbles (in_valid low) SHALL propagate as invalid stages; outputs S/flags/tag are don't-care while out_valid is low but SHALL not change while out_valid is high and stalled.
REQ-030 Accept and consume on the same edge SHALL both take effect.
REQ-031 Results SHALL leave in acceptance order.

Reset
REQ-032 On reset all stage valids, out_valid, S, carryout, flags and out_tag SHALL be 0; in_ready SHALL be 1 the cycle after reset.
REQ-033 Reset mid-operation SHALL discard all in-flight operations; none emerge afterwards.
REQ-034 Reset SHALL take priority over accept and consume in the same cycle.

Structure
REQ-035 Op encoding constants (ADD/SUB) SHALL live in shared package klp32_alu_pkg.
REQ-036 Per-chunk combinational ripple adder SHALL be sub-module addsub_chunk (parameter CW; ports a, b, cin, sum, cout), instantiated STAGES times.
REQ-037 No latches; all sequential logic in clocked blocks on clk.

Verification
REQ-038 WIDTH=32, STAGES=4, ADD X=0xFFFFFFFF Y=0x00000001 cin=0 -> after 4 cycles S=0, carryout=1, zero=1, overflow=0.
REQ-039 SUB X=0x80000000 Y=0x00000001 cin=0 -> S=0x7FFFFFFF, carryout=1, overflow=1, negative=0.
REQ-040 Back-to-back 8 ops tags 0..7, out_ready=1 -> outputs on 8 consecutive cycles, tags 0..7 in order, matching a reference model.
REQ-041 out_ready low 3 cycles with pipeline full -> in_ready=0, S/tag held stable, no loss; release -> remaining results in order.
REQ-042 Reset asserted with 3 ops in flight -> out_valid stays 0 for next STAGES cycles; new op afterwards returns correctly.
REQ-043 STAGES=1 and STAGES=8, WIDTH=16, 1000 random ops with random valid/ready -> all results match model, latency equals STAGES when unstalled.
